// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the architectural PC, issues one imem read
// at a time, buffers the returned word and hands it to decode over valid/ready.
// A late redirect overrides the PC and squashes in-flight work.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned-PC fault instead of a read).
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] pc,
  input  logic [63:0] next_pc,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault,
  input  logic        if_ready
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [63:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_fault_q, if_fault_d;
  logic        misaligned;
  logic        req_fire;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned    = (pc_q[1:0] != 2'b00);
  assign imem_req_addr = pc_q;
`else
  assign misaligned    = 1'b0;
  assign imem_req_addr = {pc_q[63:2], 2'b00};
`endif

  // A misaligned PC never reaches memory; REQ turns it into a fault instead.
  assign imem_req_valid = (state_q == StReq) && !misaligned;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign pc       = pc_q;
  assign if_valid = (state_q == StHold);
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;
  assign if_fault = if_fault_q;

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_pc_q    <= 64'h0;
      if_instr_q <= 32'h0;
      if_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_fault_q <= if_fault_d;
    end
  end

  // Next-state logic; redirect takes priority in every state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_fault_d = if_fault_q;
    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (redirect) pc_d = redirect_pc;
      end
      StReq: begin
        if (redirect) begin
          pc_d = redirect_pc;
          // A request accepted alongside the redirect still owes a response; drop it.
          if (req_fire) begin
            drop_d  = 1'b1;
            state_d = StWait;
          end
        end else if (misaligned) begin
          if_pc_d    = pc_q;
          if_instr_d = 32'h0;
          if_fault_d = 1'b1;
          state_d    = StHold;
        end else if (req_fire) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect) begin
          pc_d = redirect_pc;
          if (imem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else begin
            if_pc_d    = pc_q;
            if_instr_d = imem_rsp_data;
            if_fault_d = 1'b0;
            state_d    = StHold;
          end
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = StReq;
        end else if (if_ready) begin
          pc_d    = next_pc;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit with RESET_PC = 64'h100.
// Honours FETCH_ALIGN_CHECK_EN for the misaligned-redirect step.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic [63:0] pc;
  logic [63:0] next_pc;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;
  logic        if_ready;

  logic        np_ovr_en;
  logic [63:0] np_ovr;
  int          passed;
  int          total;
  int          accepts;
  int          acc_snap;

  // Memory model state
  logic        pend;
  int          cnt;
  int          lat;
  logic [63:0] paddr;

  assign next_pc = np_ovr_en ? np_ovr : pc + 64'd4;

  pc_fetch_unit #(.RESET_PC(64'h100)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc             (pc),
    .next_pc        (next_pc),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_fault       (if_fault),
    .if_ready       (if_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  // Record an accepted request.
  always @(posedge clk) begin
    if (reset_n && imem_req_valid && imem_req_ready) begin
      pend    = 1'b1;
      cnt     = lat;
      paddr   = imem_req_addr;
      accepts = accepts + 1;
    end
  end

  // Present the response lat cycles after the cycle following acceptance.
  always @(negedge clk) begin
    imem_rsp_valid = 1'b0;
    if (!reset_n) begin
      pend = 1'b0;
    end else if (pend) begin
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(paddr);
        pend           = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    passed = 0; total = 0; accepts = 0; pend = 1'b0; cnt = 0; lat = 0; paddr = '0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; if_ready = 1'b1; np_ovr_en = 1'b0; np_ovr = '0;

    // Reset state
    step(2);
    check("rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
    check("rst_req_addr", imem_req_addr, 64'h100);
    check("rst_pc", pc, 64'h100);
    check("rst_if_valid", {63'b0, if_valid}, 64'd0);
    check("rst_if_pc", if_pc, 64'h0);
    check("rst_if_instr", {32'b0, if_instr}, 64'h0);
    check("rst_if_fault", {63'b0, if_fault}, 64'd0);
    reset_n = 1'b1;

    // Sequential fetch, zero-wait memory, one instruction per 3 cycles
    step(1);
    check("f0_req_valid", {63'b0, imem_req_valid}, 64'd1);
    check("f0_req_addr", imem_req_addr, 64'h100);
    step(1);
    check("f0_wait_req_valid", {63'b0, imem_req_valid}, 64'd0);
    step(1);
    check("f0_if_valid", {63'b0, if_valid}, 64'd1);
    check("f0_if_pc", if_pc, 64'h100);
    check("f0_if_instr", {32'b0, if_instr}, {32'b0, instr_of(64'h100)});
    step(1);
    check("f1_req_addr", imem_req_addr, 64'h104);
    check("f1_pc", pc, 64'h104);
    check("f1_if_valid", {63'b0, if_valid}, 64'd0);

    // Memory stalls for 4 cycles: request held stable
    imem_req_ready = 1'b0;
    acc_snap = accepts;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("stall_req_valid", {63'b0, imem_req_valid}, 64'd1);
      check("stall_req_addr", imem_req_addr, 64'h104);
    end
    imem_req_ready = 1'b1;
    step(1);
    check("stall_accept_once", 64'(accepts - acc_snap), 64'd1);
    check("stall_wait_req_valid", {63'b0, imem_req_valid}, 64'd0);
    step(1);
    check("f1_if_pc", if_pc, 64'h104);

    // Decode back-pressure for 5 cycles in HOLD
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("bp_if_valid", {63'b0, if_valid}, 64'd1);
      check("bp_if_pc", if_pc, 64'h104);
      check("bp_if_instr", {32'b0, if_instr}, {32'b0, instr_of(64'h104)});
      check("bp_pc", pc, 64'h104);
    end
    if_ready = 1'b1;
    step(1);
    check("f2_pc", pc, 64'h108);
    check("f2_req_addr", imem_req_addr, 64'h108);

    // Redirect while waiting on a 3-cycle response
    lat = 2;
    step(1);
    redirect = 1'b1; redirect_pc = 64'h2000;
    step(1);
    redirect = 1'b0;
    check("rw_pc", pc, 64'h2000);
    check("rw_req_valid", {63'b0, imem_req_valid}, 64'd0);
    step(1);
    check("rw_if_valid_a", {63'b0, if_valid}, 64'd0);
    step(1);
    check("rw_if_valid_b", {63'b0, if_valid}, 64'd0);
    check("rw_req_valid2", {63'b0, imem_req_valid}, 64'd1);
    check("rw_req_addr", imem_req_addr, 64'h2000);
    lat = 0;
    step(2);
    check("rw_if_pc", if_pc, 64'h2000);
    check("rw_if_instr", {32'b0, if_instr}, {32'b0, instr_of(64'h2000)});

    // Redirect coincident with a HOLD handoff
    np_ovr_en = 1'b1; np_ovr = 64'h108;
    redirect = 1'b1; redirect_pc = 64'h400;
    step(1);
    redirect = 1'b0; np_ovr_en = 1'b0;
    check("rh_pc", pc, 64'h400);
    check("rh_req_addr", imem_req_addr, 64'h400);
    check("rh_if_valid", {63'b0, if_valid}, 64'd0);

    // Redirect to a misaligned target while in REQ
    imem_req_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 64'h402;
    step(1);
    redirect = 1'b0; imem_req_ready = 1'b1;
    check("ma_pc", pc, 64'h402);
`ifdef FETCH_ALIGN_CHECK_EN
    check("ma_req_valid", {63'b0, imem_req_valid}, 64'd0);
    step(1);
    check("ma_if_valid", {63'b0, if_valid}, 64'd1);
    check("ma_if_fault", {63'b0, if_fault}, 64'd1);
    check("ma_if_pc", if_pc, 64'h402);
    check("ma_if_instr", {32'b0, if_instr}, 64'h0);
`else
    check("ma_req_valid", {63'b0, imem_req_valid}, 64'd1);
    check("ma_req_addr", imem_req_addr, 64'h400);
    step(2);
    check("ma_if_valid", {63'b0, if_valid}, 64'd1);
    check("ma_if_fault", {63'b0, if_fault}, 64'd0);
    check("ma_if_pc", if_pc, 64'h402);
    check("ma_if_instr", {32'b0, if_instr}, {32'b0, instr_of(64'h400)});
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch front end that owns the architectural program counter. It presents the current PC to the next-PC calculator and issues one instruction-memory read at a time. It buffers the returned instruction word and hands it to decode over a valid/ready handshake. At each handoff it loads the calculator's `next_pc`; a late branch resolution can override this with `redirect`/`redirect_pc`, which squashes in-flight work.

## Interface
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `pc`, output, 64: current PC, driven to the next-PC calculator.
- `next_pc`, input, 64: sequential or branch target from the next-PC calculator; sampled only at handoff.
- `redirect`, input, 1: late branch resolution; flush the fetch and load `redirect_pc`.
- `redirect_pc`, input, 64: redirect target.
- `imem_req_valid`, output, 1: a read request is pending.
- `imem_req_addr`, output, 64: read address.
- `imem_req_ready`, input, 1: memory accepts the request.
- `imem_rsp_valid`, input, 1: read data is valid; in order, exactly one response per accepted request.
- `imem_rsp_data`, input, 32: instruction word.
- `if_valid`, output, 1: the fetched instruction is valid.
- `if_pc`, output, 64: PC of the fetched instruction.
- `if_instr`, output, 32: the fetched instruction.
- `if_fault`, output, 1: misaligned-PC fault flag (see Configuration).
- `if_ready`, input, 1: decode accepts the instruction.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: the state entered on reset. It always advances to REQ on the next cycle.
- REQ: `imem_req_valid`=1 and `imem_req_addr`=`pc`.
  - On `imem_req_ready`=1, go to WAIT.
  - Address and valid stay stable until accepted; a redirect is the only event that changes them.
- WAIT: wait for `imem_rsp_valid`.
  - On the response, capture `if_instr`<=`imem_rsp_data` and `if_pc`<=`pc`, then go to HOLD.
  - If the drop flag is set, discard the data, clear the flag and go to REQ instead.
- HOLD: `if_valid`=1.
  - On `if_valid && if_ready`, load `pc`<=`next_pc` and go to REQ.
- Redirect has the highest priority in every state. It always loads `pc`<=`redirect_pc`. Per state:
  - IDLE/REQ without acceptance: stay in or enter REQ with the new address.
  - REQ with `imem_req_ready`=1 in the same cycle: the request counts as accepted. Set the drop flag and go to WAIT.
  - WAIT: set the drop flag. If `imem_rsp_valid` arrives in the same cycle, drop the response and go to REQ.
  - HOLD: `if_valid` falls next cycle and the state goes to REQ. A handoff in the same cycle is void: `next_pc` is ignored and decode must treat that instruction as squashed.
- `if_pc`, `if_instr` and `if_fault` are registered and stable while `if_valid`=1.
- A response that arrives while in REQ or HOLD is a protocol error and is ignored.
- There is never more than one outstanding request.

## Timing
- Reset (`reset_n`=0 at an edge): `pc`=RESET_PC, state IDLE, drop flag 0. Resulting outputs:
  - `imem_req_valid`=0, `imem_req_addr`=RESET_PC.
  - `if_valid`=0, `if_pc`=0, `if_instr`=0, `if_fault`=0.
- Reset mid-transaction: outstanding responses are not tracked after reset. The memory must be reset in the same cycle.
- First request: `imem_req_valid` is 1 in the 2nd cycle after reset is released.
- Best-case throughput, with zero-wait memory and `if_ready` held at 1:
  - Cycle 0: request accepted.
  - Cycle 1: response arrives.
  - Cycle 2: `if_valid`=1 and handoff.
  - Cycle 3: next request.
  - Steady state is one instruction per 3 cycles.
- Redirect latency: the request to `redirect_pc` is issued 1 cycle after `redirect`, unless a response is being dropped (WAIT state).
- PC arithmetic: none is done in this block; it passes full 64-bit values through.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - In REQ with `pc[1:0]`≠0, no request is issued.
  - The block goes straight to HOLD with `if_fault`=1, `if_instr`=32'h0 and `if_pc`=`pc`.
  - Handoff and redirect rules are unchanged.
- `FETCH_ALIGN_CHECK_EN` undefined:
  - `imem_req_addr` = {`pc[63:2]`, 2'b00}.
  - `if_fault` is tied to 0.

## Test plan
- Reset with RESET_PC=64'h100, `next_pc`=`pc`+4, zero-wait memory, `if_ready`=1 -> request addresses 100, 104, 108; `if_pc` values match, one instruction every 3 cycles.
- `imem_req_ready` held low for 4 cycles -> `imem_req_addr` stays stable at 64'h104 and `imem_req_valid` stays 1; exactly one request is accepted.
- `if_ready` low for 5 cycles while in HOLD -> `if_instr`/`if_pc` stay stable; `pc` changes only at the handoff.
- Redirect to 64'h2000 while in WAIT, 3-cycle memory latency -> the stale response is not presented; the next `imem_req_addr`=64'h2000.
- Redirect in the same cycle as an HOLD handoff with `next_pc`=64'h108 and `redirect_pc`=64'h400 -> `pc`=64'h400 and the next request is 400.
- With `FETCH_ALIGN_CHECK_EN` defined, `redirect_pc`=64'h402 -> no request issued, `if_valid`=1, `if_fault`=1, `if_pc`=64'h402. Without the macro, the request address is 64'h400.
